// File: rtl/chipmunk_stack_engine.sv
// chipmunk_stack_engine
// Command-driven hardware stack controller. Pushes and pulls single bytes or
// one/two-byte return addresses through a req/ack byte memory port that may
// insert wait states. Tracks fill level, derives the descending stack pointer,
// and raises sticky overflow/underflow flags on rejected commands.
module chipmunk_stack_engine #(
  parameter int ADDR_W     = 12,
  parameter int PC_W       = 12,
  parameter int SP_W       = 6,
  parameter int STACK_BASE = 'h100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_data,
  input  logic [PC_W-1:0]   cmd_addr,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [7:0]        rsp_data,
  output logic [PC_W-1:0]   rsp_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [SP_W-1:0]   sp,
  output logic [SP_W:0]     level,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  // Bytes per return address and stack geometry.
  localparam int                NB    = (PC_W <= 8) ? 1 : 2;
  localparam int                DEPTH = 1 << SP_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(STACK_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Memory address of a stack slot; wraps within the address space.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SP_W-1:0] s);
    return BASE + ADDR_W'(s);
  endfunction

  // High byte of a return address, zero padded above PC_W.
  function automatic logic [7:0] addr_hi(input logic [PC_W-1:0] a);
    return 8'(16'(a) >> 8);
  endfunction

  // Low byte of a return address, zero padded when PC_W is below 8.
  function automatic logic [7:0] addr_lo(input logic [PC_W-1:0] a);
    return 8'(16'(a));
  endfunction

  state_t              r_state;
  logic [1:0]          r_op;
  logic [1:0]          r_n;
  logic                r_idx;
  logic [SP_W-1:0]     r_slot;
  logic [SP_W:0]       r_level;
  logic                r_ovf;
  logic                r_udf;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [7:0]          r_rsp_data;
  logic [PC_W-1:0]     r_rsp_addr;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic [PC_W-1:0]     r_addr;

  logic                w_idle;
  logic                w_accept;
  logic                w_push;
  logic                w_isaddr;
  logic [1:0]          w_n;
  logic [SP_W-1:0]     w_sp;
  logic                w_over;
  logic                w_under;
  logic                w_err;
  logic [SP_W-1:0]     w_slot_first;
  logic                w_r_push;
  logic                w_r_isaddr;
  logic [SP_W-1:0]     w_slot_next;
  logic                w_cap_hi;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = cmd_valid && w_idle;
  assign w_push   = ~cmd_op[0];
  assign w_isaddr = cmd_op[1];
  assign w_n      = w_isaddr ? 2'(NB) : 2'd1;

  // The stack grows downward from the top slot: sp = (DEPTH-1-level) mod DEPTH.
  assign w_sp     = ~r_level[SP_W-1:0];

  // Reject a push that does not fit in the free space, or a pull of more
  // bytes than are stacked.
  assign w_over   = ((SP_W+2)'(r_level) + (SP_W+2)'(w_n)) > (SP_W+2)'(DEPTH);
  assign w_under  = r_level < (SP_W+1)'(w_n);
  assign w_err    = w_push ? w_over : w_under;

  // Push writes at sp; pull reads the slot just above sp.
  assign w_slot_first = w_push ? w_sp : w_sp + SP_W'(1);

  // Consecutive bytes of one address walk downward for push, upward for pull.
  assign w_r_push    = ~r_op[0];
  assign w_r_isaddr  = r_op[1];
  assign w_slot_next = w_r_push ? r_slot - SP_W'(1) : r_slot + SP_W'(1);

  // A pulled two-byte address arrives high byte first.
  assign w_cap_hi    = (NB == 2) && w_r_isaddr && !r_idx;

  assign cmd_ready = w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign rsp_addr  = r_rsp_addr;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign sp        = w_sp;
  assign level     = r_level;
  assign full      = (r_level == (SP_W+1)'(DEPTH));
  assign overflow  = r_ovf;
  assign underflow = r_udf;

  // Return address latched at acceptance; only needed for the second pushed byte.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= cmd_addr;
    end
  end

  // Command FSM: accept/check in IDLE, byte transfers in MEM, one-cycle response in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_n         <= 2'd0;
      r_idx       <= 1'b0;
      r_slot      <= '0;
      r_level     <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;

      // Clearing is overridden below when a new error is flagged this cycle.
      if (clr_err) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op  <= cmd_op;
            r_n   <= w_n;
            r_idx <= 1'b0;
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              if (w_push) begin
                r_ovf <= 1'b1;
              end else begin
                r_udf <= 1'b1;
              end
            end else begin
              r_state     <= S_MEM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_push;
              r_slot      <= w_slot_first;
              r_mem_addr  <= slot_addr(w_slot_first);
              r_mem_wdata <= w_isaddr ? addr_lo(cmd_addr) : cmd_data;
            end
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            if (w_r_push) begin
              r_level <= r_level + (SP_W+1)'(1);
            end else begin
              r_level <= r_level - (SP_W+1)'(1);
              if (!w_r_isaddr) begin
                r_rsp_data <= mem_rdata;
              end else if (w_cap_hi) begin
                r_rsp_addr <= PC_W'({mem_rdata, addr_lo(r_rsp_addr)});
              end else begin
                r_rsp_addr <= PC_W'({addr_hi(r_rsp_addr), mem_rdata});
              end
            end
            r_n   <= r_n - 2'd1;
            r_idx <= 1'b1;
            if (r_n > 2'd1) begin
              r_slot      <= w_slot_next;
              r_mem_addr  <= slot_addr(w_slot_next);
              r_mem_wdata <= addr_hi(r_addr);
            end else begin
              r_state     <= S_RESP;
              r_mem_req   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
            end
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chipmunk_stack_engine.sv
// Directed bench for chipmunk_stack_engine with a byte memory model behind
// the req/ack port and a log of every acknowledged access.
module tb_chipmunk_stack_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [11:0] cmd_addr;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_data;
  logic [11:0] rsp_addr;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [5:0]  sp;
  logic [6:0]  level;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0]  mem      [0:4095];
  logic [11:0] log_addr [0:255];
  logic        log_we   [0:255];
  logic [7:0]  log_data [0:255];
  int          log_cnt  = 0;
  int          req_cnt  = 0;

  chipmunk_stack_engine dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_addr  (cmd_addr),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .sp        (sp),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory model and access log.
  always @(posedge clk) begin
    if (reset && mem_req) begin
      req_cnt <= req_cnt + 1;
      if (mem_ack) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        log_addr[log_cnt[7:0]] <= mem_addr;
        log_we[log_cnt[7:0]]   <= mem_we;
        log_data[log_cnt[7:0]] <= mem_we ? mem_wdata : mem_rdata;
        log_cnt <= log_cnt + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Issue one command, return cycles from acceptance to rsp_valid and rsp_err.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [11:0] a,
                         input logic clr, output int lat, output logic err);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_addr  = a;
    clr_err   = clr;
    @(negedge clk);
    cmd_valid = 1'b0;
    clr_err   = 1'b0;
    cmd_data  = 8'h00;
    cmd_addr  = 12'h000;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    err = rsp_err;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    int   lat;
    logic err;
    logic any_err;
    int   base;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_addr  = 12'h000;
    clr_err   = 1'b0;
    mem_ack   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_sp", sp, 'h3F);
    chk("rst_level", level, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_full", full, 0);
    reset = 1'b1;

    // 1: push byte 0x5A, cycle-exact
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_req", mem_req, 1);
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 'h13F);
    chk("t1_wdata", mem_wdata, 'h5A);
    chk("t1_busy", cmd_ready, 0);
    chk("t1_rsp_early", rsp_valid, 0);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_sp", sp, 'h3E);
    chk("t1_level", level, 1);
    chk("t1_req_done", mem_req, 0);
    @(negedge clk);
    chk("t1_rsp_pulse", rsp_valid, 0);
    chk("t1_ready", cmd_ready, 1);

    // 2: push then pull address 0xABC
    do_reset();
    base = log_cnt;
    run_cmd(2'b10, 8'h00, 12'hABC, 1'b0, lat, err);
    chk("t2_push_lat", lat, 3);
    chk("t2_push_err", err, 0);
    chk("t2_w0_addr", log_addr[base], 'h13F);
    chk("t2_w0_data", log_data[base], 'hBC);
    chk("t2_w1_addr", log_addr[base+1], 'h13E);
    chk("t2_w1_data", log_data[base+1], 'h0A);
    chk("t2_w1_we", log_we[base+1], 1);
    chk("t2_push_sp", sp, 'h3D);
    chk("t2_push_level", level, 2);
    run_cmd(2'b11, 8'h00, 12'h000, 1'b0, lat, err);
    chk("t2_pull_lat", lat, 3);
    chk("t2_pull_err", err, 0);
    chk("t2_r0_addr", log_addr[base+2], 'h13E);
    chk("t2_r0_we", log_we[base+2], 0);
    chk("t2_r1_addr", log_addr[base+3], 'h13F);
    chk("t2_rsp_addr", rsp_addr, 'hABC);
    chk("t2_pull_level", level, 0);
    chk("t2_pull_sp", sp, 'h3F);

    // 3: pull byte from empty
    base = req_cnt;
    run_cmd(2'b01, 8'h00, 12'h000, 1'b0, lat, err);
    chk("t3_lat", lat, 1);
    chk("t3_err", err, 1);
    chk("t3_no_req", req_cnt, base);
    chk("t3_udf", underflow, 1);
    chk("t3_ovf", overflow, 0);
    chk("t3_level", level, 0);
    pulse_clr();
    chk("t3_udf_clr", underflow, 0);

    // 4: fill to the top, overflow detection
    do_reset();
    any_err = 1'b0;
    for (int i = 0; i < 63; i++) begin
      run_cmd(2'b00, 8'(i), 12'h000, 1'b0, lat, err);
      any_err = any_err | err;
    end
    chk("t4_fill_err", any_err, 0);
    chk("t4_fill_level", level, 63);
    chk("t4_fill_sp", sp, 'h00);
    run_cmd(2'b10, 8'h00, 12'h123, 1'b0, lat, err);
    chk("t4_addr_lat", lat, 1);
    chk("t4_addr_err", err, 1);
    chk("t4_ovf", overflow, 1);
    chk("t4_addr_level", level, 63);
    pulse_clr();
    chk("t4_ovf_clr", overflow, 0);
    base = log_cnt;
    run_cmd(2'b00, 8'hAA, 12'h000, 1'b0, lat, err);
    chk("t4_last_err", err, 0);
    chk("t4_last_addr", log_addr[base], 'h100);
    chk("t4_full_level", level, 64);
    chk("t4_full", full, 1);
    chk("t4_full_sp", sp, 'h3F);
    run_cmd(2'b00, 8'h55, 12'h000, 1'b1, lat, err);
    chk("t4_rej_err", err, 1);
    chk("t4_set_wins", overflow, 1);
    chk("t4_rej_level", level, 64);
    run_cmd(2'b01, 8'h00, 12'h000, 1'b0, lat, err);
    chk("t4_pull_err", err, 0);
    chk("t4_pull_data", rsp_data, 'hAA);
    chk("t4_pull_level", level, 63);

    // 5: wait states during pull address
    do_reset();
    run_cmd(2'b10, 8'h00, 12'h5C3, 1'b0, lat, err);
    chk("t5_push_err", err, 0);
    mem_ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("t5_wait_req", mem_req, 1);
      chk("t5_wait_addr", mem_addr, 'h13E);
      chk("t5_wait_we", mem_we, 0);
      chk("t5_wait_ready", cmd_ready, 0);
      chk("t5_wait_level", level, 2);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t5_b1_addr", mem_addr, 'h13F);
    chk("t5_b1_req", mem_req, 1);
    chk("t5_b1_level", level, 1);
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_err", rsp_err, 0);
    chk("t5_rsp_addr", rsp_addr, 'h5C3);
    chk("t5_level", level, 0);

    // 6: async reset in the middle of a push address
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_addr  = 12'hABC;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_b0_addr", mem_addr, 'h13F);
    @(negedge clk);
    chk("t6_b1_req", mem_req, 1);
    chk("t6_b1_level", level, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_sp", sp, 'h3F);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_idle_req", mem_req, 0);
    base = log_cnt;
    run_cmd(2'b00, 8'h77, 12'h000, 1'b0, lat, err);
    chk("t6_after_lat", lat, 2);
    chk("t6_after_addr", log_addr[base], 'h13F);
    chk("t6_after_level", level, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
